// File: rtl/writeback_stage.sv
// writeback_stage: final RV64I pipeline stage.
// Holds the MEM/WB register, with stall and flush handling.
// Extracts and extends load data (lb/lh/lw/ld/lbu/lhu/lwu).
// Selects the write-back source and drives the register-file write port.
// Counts retired instructions.
// Optional macro WB_MISALIGN_CHECK_EN flags misaligned lh/lw/ld loads and
// suppresses their register write. Without the macro, misaligned is tied
// to 0 and misaligned loads read shifted lanes, with zero fill.
module writeback_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic                  is_jump,
    input  logic [2:0]            funct3,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       mem_data,
    input  logic [XLEN-1:0]       pc_plus4,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_valid,
    output logic                  misaligned,
    output logic [CNT_W-1:0]      retired_count
);

    // Shift the doubleword down by the byte offset.
    // Lanes past byte 7 become zero; there is no wrap.
    // Then apply the size and sign rules of funct3.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] data,
        input logic [2:0]      off
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = data >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{(XLEN-8){sh[7]}},   sh[7:0]};
            3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  res = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'b100:  res = {{(XLEN-8){1'b0}},    sh[7:0]};
            3'b101:  res = {{(XLEN-16){1'b0}},   sh[15:0]};
            3'b110:  res = {{(XLEN-32){1'b0}},   sh[31:0]};
            // 011 (ld) and reserved 111 both return the whole doubleword.
            default: res = sh;
        endcase
        return res;
    endfunction

`ifdef WB_MISALIGN_CHECK_EN
    // Natural-alignment check for the signed multi-byte loads lh, lw and ld.
    function automatic logic load_misaligned(
        input logic [2:0] f3,
        input logic [2:0] off
    );
        logic res;
        case (f3)
            3'b001:  res = off[0];
            3'b010:  res = |off[1:0];
            3'b011:  res = |off;
            default: res = 1'b0;
        endcase
        return res;
    endfunction
`endif

    logic                  valid_q, valid_d;
    logic                  en_q,    en_d;
    logic [REG_ADDR_W-1:0] rd_q,    rd_d;
    logic [XLEN-1:0]       data_q,  data_d;
    logic                  mis_q,   mis_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [XLEN-1:0]       src_data_s;
    logic                  mis_s;

    // Misaligned-load detection for the instruction being captured.
`ifdef WB_MISALIGN_CHECK_EN
    assign mis_s = in_valid & mem_to_reg & ~is_jump
                 & load_misaligned(funct3, alu_result[2:0]);
`else
    assign mis_s = 1'b0;
`endif

    // Write-back source select. A jump overrides a load.
    always_comb begin
        src_data_s = alu_result;
        if (is_jump) begin
            src_data_s = pc_plus4;
        end else if (mem_to_reg) begin
            src_data_s = load_extract(funct3, mem_data, alu_result[2:0]);
        end else begin
            src_data_s = alu_result;
        end
    end

    // Next state for the stage register. Flush takes priority over stall,
    // and stall takes priority over capture.
    always_comb begin
        valid_d = valid_q;
        en_d    = en_q;
        rd_d    = rd_q;
        data_d  = data_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            en_d    = 1'b0;
            rd_d    = {REG_ADDR_W{1'b0}};
            data_d  = {XLEN{1'b0}};
            mis_d   = 1'b0;
        end else if (stall) begin
            // Stall: every output, including the counter, holds its value.
            valid_d = valid_q;
            cnt_d   = cnt_q;
        end else begin
            valid_d = in_valid;
            en_d    = in_valid & reg_write & (rd != {REG_ADDR_W{1'b0}}) & ~mis_s;
            rd_d    = rd;
            data_d  = src_data_s;
            mis_d   = mis_s;
            cnt_d   = in_valid ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
        end
    end

    // Stage register with synchronous reset. Reset discards any held instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            rd_q    <= {REG_ADDR_W{1'b0}};
            data_q  <= {XLEN{1'b0}};
            mis_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            en_q    <= en_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid      = valid_q;
    assign wb_en         = en_q;
    assign wb_rd         = rd_q;
    assign wb_data       = data_q;
    assign misaligned    = mis_q;
    assign retired_count = cnt_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final stage of the RV64I datapath. It sits directly downstream of the memory access stage and consumes its 64-bit `mem_data` together with the ALU result and control.
- Contains the MEM/WB pipeline register with stall/flush handling.
- Performs load-data byte selection and sign/zero extension (lb/lh/lw/ld/lbu/lhu/lwu).
- Selects the write-back source and drives the register-file write port.
- Keeps a retired-instruction counter.

Parameters:
- XLEN, 64, datapath width.
- REG_ADDR_W, 5, register index width.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream holds a real instruction this cycle.
- stall  input  1  hold the stage register.
- flush  input  1  replace the captured instruction with a bubble.
- reg_write  input  1  instruction writes rd.
- mem_to_reg  input  1  result comes from memory (load).
- is_jump  input  1  result is pc_plus4 (jal/jalr).
- funct3  input  3  load size/sign code.
- rd  input  REG_ADDR_W  destination register.
- alu_result  input  XLEN  ALU result; doubles as the load address.
- mem_data  input  XLEN  aligned doubleword from data memory.
- pc_plus4  input  XLEN  link value.
- wb_en  output  1  register-file write enable.
- wb_rd  output  REG_ADDR_W  register-file write index.
- wb_data  output  XLEN  register-file write data.
- wb_valid  output  1  a real instruction is retiring this cycle.
- misaligned  output  1  misaligned-load flag; see Optional Feature.
- retired_count  output  CNT_W  number of instructions retired.

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high on `reset`.
- All outputs are registered. Latency is 1 cycle from the capture edge to the outputs.
- Reset values: wb_en=0, wb_rd=0, wb_data=0, wb_valid=0, misaligned=0, retired_count=0.
- Reset asserted mid-operation discards the held instruction. The following cycle shows reset values.
- Priority at each posedge: reset > flush > stall > capture.
  - Flush: wb_valid=0 and wb_en=0. wb_rd and wb_data are don't-care (drive 0).
  - Stall without flush: all outputs hold their values. The counter does not re-increment.
  - Capture: wb_valid=in_valid and wb_en=in_valid & reg_write & (rd!=0).
- Writes to x0 are never enabled, although wb_valid may still be 1.
- Source select:
  - is_jump → pc_plus4.
  - else mem_to_reg → load-extracted value.
  - else alu_result.
  - If is_jump and mem_to_reg are both 1, is_jump wins.
- Load extraction uses offset = alu_result[2:0], selecting little-endian byte lanes from mem_data:
  - funct3 000 lb: byte[offset], sign-extended.
  - 001 lh: halfword at offset, sign-extended.
  - 010 lw: word at offset, sign-extended.
  - 011 ld: full mem_data.
  - 100 lbu, 101 lhu, 110 lwu: zero-extended.
  - 111 (reserved): treated as ld.
- Misaligned offsets, with the feature disabled: the lanes are taken from mem_data >> (8*offset), with no wrap. Bytes beyond lane 7 read as 0 before extension.
- retired_count increments by 1 on each posedge where wb_valid is registered to 1. It wraps modulo 2^CNT_W and is not affected by stall cycles.

Optional Feature:
- Macro: WB_MISALIGN_CHECK_EN.
- Defined:
  - Detect misaligned loads on capture: lh with offset[0]≠0, lw with offset[1:0]≠0, ld with offset≠0.
  - Detection applies only when mem_to_reg & in_valid and not is_jump.
  - For such a load: misaligned=1 and wb_en=0. wb_valid stays 1 and the instruction is counted.
  - misaligned clears on the next capture or flush.
- Undefined: misaligned is tied to 0 and misaligned loads follow the shift rule above.

Test Plan:
- Reset, then lb at alu_result=0x1000, mem_data=0x0000_0000_0000_0080, rd=5 → next cycle wb_en=1, wb_rd=5, wb_data=0xFFFF_FFFF_FFFF_FF80, retired_count=1.
- lhu at alu_result=0x1006, mem_data=0xBEEF_0000_0000_0000 → wb_data=0x0000_0000_0000_BEEF. Same access with lh → 0xFFFF_FFFF_FFFF_BEEF.
- jal with is_jump=1, mem_to_reg=1, rd=1, pc_plus4=0x104, alu_result=0x200 → wb_data=0x104 and wb_en=1. An add to rd=0 → wb_en=0, wb_valid=1.
- Capture an instruction with alu_result=0x55, then hold stall=1 for 3 cycles → outputs constant and retired_count unchanged. Then assert stall=1 and flush=1 together → wb_valid=0, wb_en=0.
- Assert reset for 1 cycle while a valid load is held under stall → all outputs 0 and retired_count=0 the next cycle.
- With WB_MISALIGN_CHECK_EN defined: lw at alu_result=0x1002 → misaligned=1, wb_en=0, wb_valid=1. A following aligned ld → misaligned=0.
